// File: rtl/srio_udp_pkg.sv
// Shared types, widths and helpers for the SRIO-to-UDP egress serialiser.
package srio_udp_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HI    = 2'd1,
        LO    = 2'd2
    } state_t;

    localparam int UDP_WIDTH   = 32;
    localparam int SRIO_WIDTH  = 64;
    localparam int KEEP_HI_MSB = 7;
    localparam int KEEP_HI_LSB = 4;
    localparam int KEEP_LO_MSB = 3;
    localparam int KEEP_LO_LSB = 0;

    function automatic logic [2:0] popcount4(input logic [3:0] keep);
        popcount4 = 3'(keep[0]) + 3'(keep[1]) + 3'(keep[2]) + 3'(keep[3]);
    endfunction

endpackage

// File: rtl/srio2udp_interface_if.sv
// Bus bundle for the serialiser: 64-bit SRIO beat input side and 32-bit UDP word output side.
interface srio2udp_interface_if #(
    parameter int LEN_WIDTH = 16
);
    import srio_udp_pkg::*;

    logic [SRIO_WIDTH-1:0] srio_data_in;
    logic [7:0]            srio_keep_in;
    logic                  srio_valid_in;
    logic                  srio_first_in;
    logic                  srio_last_in;
    logic [LEN_WIDTH-1:0]  srio_length_in;
    logic                  srio_ready_out;

    logic [UDP_WIDTH-1:0]  udp_data_out;
    logic [3:0]            udp_keep_out;
    logic                  udp_valid_out;
    logic                  udp_first_out;
    logic                  udp_last_out;
    logic [LEN_WIDTH-1:0]  udp_length_out;
    logic                  udp_ready_in;

    // Upstream FIFO / downstream UDP engine side.
    modport master (
        output srio_data_in, srio_keep_in, srio_valid_in, srio_first_in,
               srio_last_in, srio_length_in, udp_ready_in,
        input  srio_ready_out, udp_data_out, udp_keep_out, udp_valid_out,
               udp_first_out, udp_last_out, udp_length_out
    );

    // The serialiser itself.
    modport slave (
        input  srio_data_in, srio_keep_in, srio_valid_in, srio_first_in,
               srio_last_in, srio_length_in, udp_ready_in,
        output srio_ready_out, udp_data_out, udp_keep_out, udp_valid_out,
               udp_first_out, udp_last_out, udp_length_out
    );

endinterface

// File: rtl/srio_udp_len_check.sv
// Output byte counter; flags (sticky) a packet whose emitted byte total differs from its declared length.
module srio_udp_len_check
    import srio_udp_pkg::*;
#(
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk_udp,
    input  logic                 reset_udp,
    input  logic                 word_hs,
    input  logic [3:0]           word_keep,
    input  logic                 word_first,
    input  logic                 word_last,
    input  logic [LEN_WIDTH-1:0] pkt_length,
    output logic                 len_err
);

    logic [LEN_WIDTH-1:0] count_reg;
    logic [LEN_WIDTH-1:0] count_next;
    logic                 len_err_reg;

    // The first word restarts the count; the sum wraps naturally at LEN_WIDTH bits.
    always_comb begin
        count_next = (word_first ? '0 : count_reg) + LEN_WIDTH'(popcount4(word_keep));
    end

    always_ff @(posedge clk_udp) begin
        if (reset_udp) begin
            count_reg   <= '0;
            len_err_reg <= 1'b0;
        end else if (word_hs) begin
            count_reg <= count_next;
            if (word_last && (count_next != pkt_length)) begin
                len_err_reg <= 1'b1;
            end
        end
    end

    assign len_err = len_err_reg;

endmodule

// File: rtl/srio2udp_interface.sv
// Serialises 64-bit SRIO beats into 32-bit UDP words, upper word first.
// Optional length check is enabled by defining SRIO2UDP_LEN_CHECK_EN.
module srio2udp_interface
    import srio_udp_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                 clk_udp,
    input  logic                 reset_udp,
    srio2udp_interface_if.slave  bus,
    output logic                 len_err_out
);

    localparam int HALF_W = DATA_WIDTH / 2;

    state_t               state_reg;
    logic [HALF_W-1:0]    hold_lo_data_reg;
    logic [3:0]           hold_lo_keep_reg;
    logic                 hold_last_reg;

    logic [UDP_WIDTH-1:0] udp_data_reg;
    logic [3:0]           udp_keep_reg;
    logic                 udp_valid_reg;
    logic                 udp_first_reg;
    logic                 udp_last_reg;
    logic [LEN_WIDTH-1:0] udp_length_reg;

    logic                 out_hs;
    logic                 final_half;
    logic                 final_hs;
    logic                 in_ready;
    logic                 accept;

    state_t               load_state;
    logic [UDP_WIDTH-1:0] load_data;
    logic [3:0]           load_keep;
    logic                 load_valid;
    logic                 load_first;
    logic                 load_last;

    logic [3:0]           in_keep_hi;
    logic [3:0]           in_keep_lo;

    assign in_keep_hi = bus.srio_keep_in[KEEP_HI_MSB:KEEP_HI_LSB];
    assign in_keep_lo = bus.srio_keep_in[KEEP_LO_MSB:KEEP_LO_LSB];

    // A HI half with an empty lower word is already the beat's last half.
    assign out_hs     = udp_valid_reg && bus.udp_ready_in;
    assign final_half = (state_reg == LO) || ((state_reg == HI) && (hold_lo_keep_reg == 4'h0));
    assign final_hs   = out_hs && final_half;
    assign in_ready   = !reset_udp && ((state_reg == EMPTY) || final_hs);
    assign accept     = bus.srio_valid_in && in_ready;

    // First emitted half of an incoming beat; a zero-keep last beat becomes an empty LO word.
    always_comb begin
        load_state = EMPTY;
        load_data  = bus.srio_data_in[HALF_W-1:0];
        load_keep  = in_keep_lo;
        load_valid = 1'b0;
        load_first = bus.srio_first_in;
        load_last  = bus.srio_last_in;
        if (in_keep_hi != 4'h0) begin
            load_state = HI;
            load_data  = bus.srio_data_in[DATA_WIDTH-1:HALF_W];
            load_keep  = in_keep_hi;
            load_valid = 1'b1;
            load_last  = bus.srio_last_in && (in_keep_lo == 4'h0);
        end else if (in_keep_lo != 4'h0) begin
            load_state = LO;
            load_valid = 1'b1;
        end else if (bus.srio_last_in) begin
            load_state = LO;
            load_keep  = 4'h0;
            load_valid = 1'b1;
        end
    end

    always_ff @(posedge clk_udp) begin
        if (reset_udp) begin
            state_reg        <= EMPTY;
            hold_lo_data_reg <= '0;
            hold_lo_keep_reg <= '0;
            hold_last_reg    <= 1'b0;
            udp_data_reg     <= '0;
            udp_keep_reg     <= '0;
            udp_valid_reg    <= 1'b0;
            udp_first_reg    <= 1'b0;
            udp_last_reg     <= 1'b0;
            udp_length_reg   <= '0;
        end else if (accept) begin
            state_reg        <= load_state;
            hold_lo_data_reg <= bus.srio_data_in[HALF_W-1:0];
            hold_lo_keep_reg <= in_keep_lo;
            hold_last_reg    <= bus.srio_last_in;
            udp_data_reg     <= load_data;
            udp_keep_reg     <= load_keep;
            udp_valid_reg    <= load_valid;
            udp_first_reg    <= load_first && load_valid;
            udp_last_reg     <= load_last && load_valid;
            if (bus.srio_first_in) begin
                udp_length_reg <= bus.srio_length_in;
            end
        end else if (out_hs) begin
            if (final_half) begin
                state_reg     <= EMPTY;
                udp_valid_reg <= 1'b0;
                udp_first_reg <= 1'b0;
                udp_last_reg  <= 1'b0;
            end else begin
                state_reg     <= LO;
                udp_data_reg  <= hold_lo_data_reg;
                udp_keep_reg  <= hold_lo_keep_reg;
                udp_first_reg <= 1'b0;
                udp_last_reg  <= hold_last_reg;
            end
        end
    end

    assign bus.srio_ready_out = in_ready;
    assign bus.udp_data_out   = udp_data_reg;
    assign bus.udp_keep_out   = udp_keep_reg;
    assign bus.udp_valid_out  = udp_valid_reg;
    assign bus.udp_first_out  = udp_first_reg;
    assign bus.udp_last_out   = udp_last_reg;
    assign bus.udp_length_out = udp_length_reg;

`ifdef SRIO2UDP_LEN_CHECK_EN
    srio_udp_len_check #(
        .LEN_WIDTH (LEN_WIDTH)
    ) u_len_check (
        .clk_udp    (clk_udp),
        .reset_udp  (reset_udp),
        .word_hs    (out_hs),
        .word_keep  (udp_keep_reg),
        .word_first (udp_first_reg),
        .word_last  (udp_last_reg),
        .pkt_length (udp_length_reg),
        .len_err    (len_err_out)
    );
`else
    assign len_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_srio2udp_interface.sv
// Directed, table-driven bench for srio2udp_interface: beat tables in, expected word tables out.
module tb_srio2udp_interface;

`ifdef SRIO2UDP_LEN_CHECK_EN
    localparam logic LEN_EN = 1'b1;
`else
    localparam logic LEN_EN = 1'b0;
`endif

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        first;
        logic        last;
        logic [15:0] length;
    } beat_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        first;
        logic        last;
    } word_t;

    typedef struct {
        string       name;
        int          b0;
        int          nb;
        int          w0;
        int          nw;
        logic [3:0]  rdy_pat;
        logic [15:0] exp_len;
        logic        exp_err;
    } case_t;

    logic clk_udp = 1'b0;
    logic reset_udp;
    logic len_err_out;

    int tests = 0;
    int fails = 0;

    beat_t beats[$];
    word_t words[$];
    case_t cases[$];

    srio2udp_interface_if #(.LEN_WIDTH(16)) bus_if ();

    srio2udp_interface #(
        .DATA_WIDTH (64),
        .LEN_WIDTH  (16)
    ) dut (
        .clk_udp     (clk_udp),
        .reset_udp   (reset_udp),
        .bus         (bus_if),
        .len_err_out (len_err_out)
    );

    always #5 clk_udp = ~clk_udp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_beat(input logic [63:0] d, input logic [7:0] k, input logic f,
                            input logic l, input logic [15:0] len);
        beat_t b;
        b.data = d; b.keep = k; b.first = f; b.last = l; b.length = len;
        beats.push_back(b);
    endtask

    task automatic add_word(input logic [31:0] d, input logic [3:0] k, input logic f, input logic l);
        word_t w;
        w.data = d; w.keep = k; w.first = f; w.last = l;
        words.push_back(w);
    endtask

    task automatic add_case(input string name, input int b0, input int w0,
                            input logic [3:0] pat, input logic [15:0] len, input logic err);
        case_t c;
        c.name = name; c.b0 = b0; c.nb = beats.size() - b0; c.w0 = w0; c.nw = words.size() - w0;
        c.rdy_pat = pat; c.exp_len = len; c.exp_err = err;
        cases.push_back(c);
    endtask

    task automatic idle_inputs();
        bus_if.srio_data_in   = '0;
        bus_if.srio_keep_in   = '0;
        bus_if.srio_valid_in  = 1'b0;
        bus_if.srio_first_in  = 1'b0;
        bus_if.srio_last_in   = 1'b0;
        bus_if.srio_length_in = '0;
    endtask

    function automatic logic [63:0] out_bus();
        return 64'({bus_if.udp_valid_out, bus_if.udp_data_out, bus_if.udp_keep_out,
                    bus_if.udp_first_out, bus_if.udp_last_out, bus_if.udp_length_out});
    endfunction

    // Called at a negedge; drives beats and ready each cycle, scores words on handshakes.
    task automatic run_case(input case_t c);
        int bi = 0;
        int wi = 0;
        int cyc = 0;
        logic stall_prev = 1'b0;
        logic [63:0] snap = '0;
        logic [63:0] cur;
        word_t w;
        beat_t b;
        while ((bi < c.nb || wi < c.nw || bus_if.udp_valid_out) && cyc < 200) begin
            if (bi < c.nb) begin
                b = beats[c.b0 + bi];
                bus_if.srio_data_in   = b.data;
                bus_if.srio_keep_in   = b.keep;
                bus_if.srio_first_in  = b.first;
                bus_if.srio_last_in   = b.last;
                bus_if.srio_length_in = b.length;
                bus_if.srio_valid_in  = 1'b1;
            end else begin
                idle_inputs();
            end
            bus_if.udp_ready_in = c.rdy_pat[cyc % 4];
            #1;
            cur = 64'({bus_if.udp_data_out, bus_if.udp_keep_out,
                       bus_if.udp_first_out, bus_if.udp_last_out});
            if (stall_prev) check({c.name, "_stall_hold"}, cur, snap);
            stall_prev = 1'b0;
            if (bus_if.udp_valid_out && !bus_if.udp_ready_in) begin
                check({c.name, "_ready_low_stall"}, 64'(bus_if.srio_ready_out), 64'd0);
                snap = cur;
                stall_prev = 1'b1;
            end
            if (bus_if.udp_valid_out && bus_if.udp_ready_in) begin
                if (wi < c.nw) begin
                    w = words[c.w0 + wi];
                    $display("[TB] %s word %0d data=%h keep=%h first=%b last=%b",
                             c.name, wi, bus_if.udp_data_out, bus_if.udp_keep_out,
                             bus_if.udp_first_out, bus_if.udp_last_out);
                    check($sformatf("%s_word%0d", c.name, wi), cur,
                          64'({w.data, w.keep, w.first, w.last}));
                    if (wi == 0) check({c.name, "_length"}, 64'(bus_if.udp_length_out), 64'(c.exp_len));
                end else begin
                    check({c.name, "_extra_word"}, 64'(bus_if.udp_valid_out), 64'd0);
                end
                wi++;
            end
            if (bus_if.srio_valid_in && bus_if.srio_ready_out) bi++;
            @(negedge clk_udp);
            cyc++;
        end
        idle_inputs();
        bus_if.udp_ready_in = 1'b1;
        check({c.name, "_timeout"}, 64'(cyc < 200), 64'd1);
        check({c.name, "_word_count"}, 64'(wi), 64'(c.nw));
        repeat (3) @(negedge clk_udp);
        check({c.name, "_len_err"}, 64'(len_err_out), 64'(c.exp_err));
    endtask

    initial begin
        int b0;
        int w0;

        // pkt16: two full beats
        b0 = beats.size(); w0 = words.size();
        add_beat(64'hA0A1A2A3_A4A5A6A7, 8'hFF, 1, 0, 16'd16);
        add_beat(64'hB0B1B2B3_B4B5B6B7, 8'hFF, 0, 1, 16'd0);
        add_word(32'hA0A1A2A3, 4'hF, 1, 0);
        add_word(32'hA4A5A6A7, 4'hF, 0, 0);
        add_word(32'hB0B1B2B3, 4'hF, 0, 0);
        add_word(32'hB4B5B6B7, 4'hF, 0, 1);
        add_case("pkt16", b0, w0, 4'b1111, 16'd16, 1'b0);

        // pkt12: lower-only tail
        b0 = beats.size(); w0 = words.size();
        add_beat(64'hC0C1C2C3_C4C5C6C7, 8'hFF, 1, 0, 16'd12);
        add_beat(64'hD0D1D2D3_D4D5D6D7, 8'h0F, 0, 1, 16'd0);
        add_word(32'hC0C1C2C3, 4'hF, 1, 0);
        add_word(32'hC4C5C6C7, 4'hF, 0, 0);
        add_word(32'hD4D5D6D7, 4'hF, 0, 1);
        add_case("pkt12", b0, w0, 4'b1111, 16'd12, 1'b0);

        // stall: ready cycles 1,0,0,1
        b0 = beats.size(); w0 = words.size();
        add_beat(64'hE0E1E2E3_E4E5E6E7, 8'hFF, 1, 0, 16'd24);
        add_beat(64'h50515253_54555657, 8'hFF, 0, 0, 16'd0);
        add_beat(64'h60616263_64656667, 8'hFF, 0, 1, 16'd0);
        add_word(32'hE0E1E2E3, 4'hF, 1, 0);
        add_word(32'hE4E5E6E7, 4'hF, 0, 0);
        add_word(32'h50515253, 4'hF, 0, 0);
        add_word(32'h54555657, 4'hF, 0, 0);
        add_word(32'h60616263, 4'hF, 0, 0);
        add_word(32'h64656667, 4'hF, 0, 1);
        add_case("stall", b0, w0, 4'b1001, 16'd24, 1'b0);

        // single: first=last, lower word only
        b0 = beats.size(); w0 = words.size();
        add_beat(64'h30313233_34353637, 8'h0F, 1, 1, 16'd4);
        add_word(32'h34353637, 4'hF, 1, 1);
        add_case("single", b0, w0, 4'b1111, 16'd4, 1'b0);

        // zero_last: empty last beat still terminates
        b0 = beats.size(); w0 = words.size();
        add_beat(64'h70717273_74757677, 8'hFF, 1, 0, 16'd8);
        add_beat(64'h0, 8'h00, 0, 1, 16'd0);
        add_word(32'h70717273, 4'hF, 1, 0);
        add_word(32'h74757677, 4'hF, 0, 0);
        add_word(32'h00000000, 4'h0, 0, 1);
        add_case("zero_last", b0, w0, 4'b1111, 16'd8, 1'b0);

        // zero_drop: empty middle beat vanishes
        b0 = beats.size(); w0 = words.size();
        add_beat(64'h80818283_84858687, 8'hFF, 1, 0, 16'd12);
        add_beat(64'h90919293_94959697, 8'h00, 0, 0, 16'd0);
        add_beat(64'hA8A9AAAB_ACADAEAF, 8'h0F, 0, 1, 16'd0);
        add_word(32'h80818283, 4'hF, 1, 0);
        add_word(32'h84858687, 4'hF, 0, 0);
        add_word(32'hACADAEAF, 4'hF, 0, 1);
        add_case("zero_drop", b0, w0, 4'b0111, 16'd12, 1'b0);

        // len_err: 20 declared, 16 sent
        b0 = beats.size(); w0 = words.size();
        add_beat(64'h11121314_15161718, 8'hFF, 1, 0, 16'd20);
        add_beat(64'h21222324_25262728, 8'hFF, 0, 1, 16'd0);
        add_word(32'h11121314, 4'hF, 1, 0);
        add_word(32'h15161718, 4'hF, 0, 0);
        add_word(32'h21222324, 4'hF, 0, 0);
        add_word(32'h25262728, 4'hF, 0, 1);
        add_case("len_err", b0, w0, 4'b1111, 16'd20, LEN_EN);

        // a correct packet afterwards must not clear the sticky flag
        b0 = beats.size(); w0 = words.size();
        add_beat(64'h31323334_35363738, 8'hF0, 1, 1, 16'd4);
        add_word(32'h31323334, 4'hF, 1, 1);
        add_case("sticky", b0, w0, 4'b1111, 16'd4, LEN_EN);

        idle_inputs();
        bus_if.udp_ready_in = 1'b1;
        reset_udp = 1'b1;
        repeat (3) @(negedge clk_udp);
        #1;
        check("reset_ready_low", 64'(bus_if.srio_ready_out), 64'd0);
        check("reset_outputs", out_bus(), 64'd0);
        check("reset_len_err", 64'(len_err_out), 64'd0);
        reset_udp = 1'b0;
        @(negedge clk_udp);
        #1;
        check("empty_ready_high", 64'(bus_if.srio_ready_out), 64'd1);
        @(negedge clk_udp);

        foreach (cases[i]) run_case(cases[i]);

        // mid-packet reset: accept one beat, then reset while its HI half is stalled
        bus_if.udp_ready_in  = 1'b0;
        bus_if.srio_data_in  = 64'hDEADBEEF_CAFEF00D;
        bus_if.srio_keep_in  = 8'hFF;
        bus_if.srio_first_in = 1'b1;
        bus_if.srio_length_in = 16'd40;
        bus_if.srio_valid_in = 1'b1;
        @(negedge clk_udp);
        idle_inputs();
        #1;
        check("midpkt_word_present", 64'(bus_if.udp_data_out), 64'hDEADBEEF);
        reset_udp = 1'b1;
        #1;
        check("midpkt_ready_low", 64'(bus_if.srio_ready_out), 64'd0);
        @(negedge clk_udp);
        #1;
        check("midpkt_outputs_zero", out_bus(), 64'd0);
        check("midpkt_len_err_zero", 64'(len_err_out), 64'd0);
        reset_udp = 1'b0;
        bus_if.udp_ready_in = 1'b1;
        @(negedge clk_udp);
        #1;
        check("post_reset_idle", 64'({bus_if.srio_ready_out, bus_if.udp_valid_out}), 64'b10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
